// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
// The optional status byte is enabled by defining ALU_SEQ_STATUS_EN.
package alu_seq_pkg;

   typedef enum logic [3:0] {
      IDLE,
      GET_AL,
      GET_AH,
      GET_BL,
      GET_BH,
      EXEC,
      WAIT,
`ifdef ALU_SEQ_STATUS_EN
      SEND_S,
`endif
      SEND_L,
      SEND_H
   } seq_state_e;

   localparam logic [3:0] FRAME_TAG = 4'hA;

   localparam logic [3:0] FUN_ADD = 4'd0;
   localparam logic [3:0] FUN_SUB = 4'd1;
   localparam logic [3:0] FUN_MUL = 4'd2;
   localparam logic [3:0] FUN_DIV = 4'd3;

   localparam int unsigned WAIT_TIMEOUT = 4;

   // A command byte carries the frame tag and one of the supported functions.
   function automatic logic is_cmd(input logic [7:0] b);
      logic fun_ok;
      case (b[3:0])
         FUN_ADD, FUN_SUB, FUN_MUL, FUN_DIV: fun_ok = 1'b1;
         default:                            fun_ok = 1'b0;
      endcase
      return (b[7:4] == FRAME_TAG) && fun_ok;
   endfunction

endpackage

// File: rtl/alu_seq_tx_ser.sv
// Byte serializer: holds the captured response and shifts it out LSB first
// over a valid/ready handshake.
module alu_seq_tx_ser
   import alu_seq_pkg::*;
#(
   parameter int unsigned N_BYTES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_i,
   input  logic [N_BYTES*8-1:0] data_i,
   input  logic                 tx_ready_i,
   output logic [7:0]           tx_data_o,
   output logic                 tx_valid_o,
   output logic                 accept_o,
   output logic                 last_o
);

   localparam int unsigned CW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

   logic [N_BYTES*8-1:0] buf_q;
   logic [CW-1:0]        left_q;
   logic                 valid_q;

   assign accept_o   = valid_q && tx_ready_i;
   assign last_o     = (left_q == '0);
   assign tx_data_o  = buf_q[7:0];
   assign tx_valid_o = valid_q;

   // The outgoing byte is always the bottom of the buffer, so it can only
   // move on an accepted handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q   <= '0;
         left_q  <= '0;
         valid_q <= 1'b0;
      end else if (load_i) begin
         buf_q   <= data_i;
         left_q  <= CW'(N_BYTES - 1);
         valid_q <= 1'b1;
      end else if (accept_o) begin
         buf_q <= buf_q >> 8;
         if (last_o) begin
            valid_q <= 1'b0;
         end else begin
            left_q <= left_q - 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Parses tagged command frames from a byte stream, drives an external ALU and
// returns the result bytes. Defining ALU_SEQ_STATUS_EN prepends a status byte.
module alu_cmd_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned OPERAND_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     RST,
   input  logic [7:0]               rx_data,
   input  logic                     rx_valid,
   output logic [OPERAND_WIDTH-1:0] alu_A,
   output logic [OPERAND_WIDTH-1:0] alu_B,
   output logic [3:0]               alu_fun,
   output logic                     arith_enable,
   input  logic [OPERAND_WIDTH-1:0] arith_out,
   input  logic                     arith_flag,
   output logic [7:0]               tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic                     busy,
   output logic                     err
);

   localparam int unsigned NB       = OPERAND_WIDTH / 8;
   localparam int unsigned IW       = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

`ifdef ALU_SEQ_STATUS_EN
   localparam int unsigned TX_BYTES   = NB + 1;
   localparam seq_state_e  SEND_FIRST = SEND_S;
`else
   localparam int unsigned TX_BYTES   = NB;
   localparam seq_state_e  SEND_FIRST = SEND_L;
`endif

   seq_state_e               state_q;
   logic [OPERAND_WIDTH-1:0] a_q;
   logic [OPERAND_WIDTH-1:0] b_q;
   logic [3:0]               fun_q;
   logic [IW-1:0]            idx_q;
   logic [2:0]               wait_q;
   logic                     en_q;
   logic                     err_q;

   logic                     ser_load;
   logic                     ser_accept;
   logic                     ser_last;
   logic [TX_BYTES*8-1:0]    ser_data;
   logic                     rx_stray;

   assign ser_load = (state_q == WAIT) && arith_flag;
   assign rx_stray = rx_valid &&
                     !(state_q inside {IDLE, GET_AL, GET_AH, GET_BL, GET_BH});

`ifdef ALU_SEQ_STATUS_EN
   assign ser_data = {arith_out, FRAME_TAG, fun_q};
`else
   assign ser_data = arith_out;
`endif

   // GET_AH/GET_BH repeat for every operand byte above the lowest one.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         fun_q   <= '0;
         idx_q   <= '0;
         wait_q  <= '0;
         en_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         en_q  <= 1'b0;
         err_q <= rx_stray;
         unique case (state_q)
            IDLE: begin
               if (rx_valid) begin
                  if (is_cmd(rx_data)) begin
                     fun_q   <= rx_data[3:0];
                     idx_q   <= '0;
                     state_q <= GET_AL;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            GET_AL, GET_AH: begin
               if (rx_valid) begin
                  a_q[idx_q*8 +: 8] <= rx_data;
                  if (idx_q == LAST_IDX) begin
                     idx_q   <= '0;
                     state_q <= GET_BL;
                  end else begin
                     idx_q   <= idx_q + 1'b1;
                     state_q <= GET_AH;
                  end
               end
            end
            GET_BL, GET_BH: begin
               if (rx_valid) begin
                  b_q[idx_q*8 +: 8] <= rx_data;
                  if (idx_q == LAST_IDX) begin
                     idx_q   <= '0;
                     en_q    <= 1'b1;
                     state_q <= EXEC;
                  end else begin
                     idx_q   <= idx_q + 1'b1;
                     state_q <= GET_BH;
                  end
               end
            end
            EXEC: begin
               wait_q  <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               if (arith_flag) begin
                  state_q <= SEND_FIRST;
               end else if (wait_q == 3'(WAIT_TIMEOUT - 1)) begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end
`ifdef ALU_SEQ_STATUS_EN
            SEND_S: begin
               if (ser_accept) begin
                  state_q <= SEND_L;
               end
            end
`endif
            SEND_L, SEND_H: begin
               if (ser_accept) begin
                  state_q <= ser_last ? IDLE : SEND_H;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   alu_seq_tx_ser #(
      .N_BYTES (TX_BYTES)
   ) u_tx_ser (
      .clk        (clk),
      .rst        (RST),
      .load_i     (ser_load),
      .data_i     (ser_data),
      .tx_ready_i (tx_ready),
      .tx_data_o  (tx_data),
      .tx_valid_o (tx_valid),
      .accept_o   (ser_accept),
      .last_o     (ser_last)
   );

   assign alu_A        = a_q;
   assign alu_B        = b_q;
   assign alu_fun      = fun_q;
   assign arith_enable = en_q;
   assign busy         = (state_q != IDLE);
   assign err          = err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed and randomized frames against a byte-level reference model,
// with a behavioural arithmetic unit of programmable latency.
module tb_alu_cmd_sequencer;

   localparam int unsigned W  = 16;
   localparam int unsigned NB = W / 8;

   logic         clk = 1'b0;
   logic         RST;
   logic [7:0]   rx_data;
   logic         rx_valid;
   logic [W-1:0] alu_A;
   logic [W-1:0] alu_B;
   logic [3:0]   alu_fun;
   logic         arith_enable;
   logic [W-1:0] arith_out;
   logic         arith_flag;
   logic [7:0]   tx_data;
   logic         tx_valid;
   logic         tx_ready;
   logic         busy;
   logic         err;

   int n_asrt = 0;
   int n_fail = 0;
   int alu_delay = 0;   // extra cycles before the ALU answers; negative = never

   alu_cmd_sequencer #(
      .OPERAND_WIDTH (W)
   ) dut (
      .clk          (clk),
      .RST          (RST),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .alu_A        (alu_A),
      .alu_B        (alu_B),
      .alu_fun      (alu_fun),
      .arith_enable (arith_enable),
      .arith_out    (arith_out),
      .arith_flag   (arith_flag),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .busy         (busy),
      .err          (err)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] ref_result(input logic [3:0] fun,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
      logic signed [W-1:0] sa;
      logic signed [W-1:0] sb;
      sa = a;
      sb = b;
      case (fun)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return W'(sa * sb);
         default: return (b == '0) ? '0 : W'(sa / sb);
      endcase
   endfunction

   // Registered arithmetic unit: result and flag appear alu_delay cycles
   // after the cycle following the enable.
   initial begin : alu_model
      int pend;
      logic [W-1:0] res;
      pend = -1;
      res = '0;
      arith_flag = 1'b0;
      arith_out = '0;
      forever begin
         @(negedge clk);
         if (RST) begin
            pend = -1;
         end else if (arith_enable) begin
            pend = alu_delay;
            res = ref_result(alu_fun, alu_A, alu_B);
         end
         @(posedge clk);
         #1;
         arith_flag = 1'b0;
         if (pend == 0) begin
            arith_flag = 1'b1;
            arith_out = res;
            pend = -1;
         end else if (pend > 0) begin
            pend--;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [3:0] fun, input logic [W-1:0] a, input logic [W-1:0] b);
      send_byte({4'hA, fun});
      for (int i = 0; i < NB; i++) send_byte(a[8*i +: 8]);
      for (int i = 0; i < NB; i++) send_byte(b[8*i +: 8]);
   endtask

   task automatic run_frame(input logic [3:0] fun, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int delay, input int stall, input bit inject);
      logic [7:0]   exp_q[$];
      logic [W-1:0] r;
      int           got;
      int           cyc;
      int           first;
      int           stall_left;
      logic         pv;
      logic         pr;
      logic [7:0]   pd;
      r = ref_result(fun, a, b);
`ifdef ALU_SEQ_STATUS_EN
      exp_q.push_back({4'hA, fun});
`endif
      for (int i = 0; i < NB; i++) exp_q.push_back(r[8*i +: 8]);
      alu_delay = delay;
      stall_left = stall;
      send_frame(fun, a, b);
      got = 0;
      cyc = 1;
      first = -1;
      pv = 1'b0;
      pr = 1'b0;
      pd = '0;
      while (got < exp_q.size() && cyc < 80) begin
         check("alu_A", 32'(alu_A), 32'(a));
         check("alu_B", 32'(alu_B), 32'(b));
         check("alu_fun", 32'(alu_fun), 32'(fun));
         check("busy", 32'(busy), 32'(1'b1));
         check("enable_pulse", 32'(arith_enable), 32'(cyc == 1));
         check("err", 32'(err), 32'(inject && cyc == 2));
         if (pv && !pr) begin
            check("hold_valid", 32'(tx_valid), 32'(1'b1));
            check("hold_data", 32'(tx_data), 32'(pd));
         end
         if (inject) begin
            rx_valid = (cyc == 1);
            rx_data = 8'($urandom);
         end
         if (tx_valid && first < 0) first = cyc;
         if (tx_valid && stall_left > 0) begin
            tx_ready = 1'b0;
            stall_left--;
         end else begin
            tx_ready = ($urandom_range(0, 3) != 0);
         end
         if (tx_valid && tx_ready) begin
            check("tx_byte", 32'(tx_data), 32'(exp_q[got]));
            got++;
         end
         pv = tx_valid;
         pr = tx_ready;
         pd = tx_data;
         @(posedge clk);
         #1;
         cyc++;
      end
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      check("frame_done", got, exp_q.size());
      check("first_valid", first, 3 + delay);
      check("idle_valid", 32'(tx_valid), 32'(1'b0));
      check("idle_busy", 32'(busy), 32'(1'b0));
   endtask

   task automatic bad_byte(input logic [7:0] b);
      send_byte(b);
      check("bad_err", 32'(err), 32'(1'b1));
      check("bad_busy", 32'(busy), 32'(1'b0));
      check("bad_en", 32'(arith_enable), 32'(1'b0));
      @(posedge clk);
      #1;
      check("bad_err_clear", 32'(err), 32'(1'b0));
      check("bad_en_late", 32'(arith_enable), 32'(1'b0));
   endtask

   task automatic run_timeout(input logic [3:0] fun, input logic [W-1:0] a, input logic [W-1:0] b);
      alu_delay = -1;
      send_frame(fun, a, b);
      for (int c = 1; c <= 8; c++) begin
         check("to_err", 32'(err), 32'(c == 6));
         check("to_busy", 32'(busy), 32'(c < 6));
         check("to_valid", 32'(tx_valid), 32'(1'b0));
         check("to_en", 32'(arith_enable), 32'(c == 1));
         tx_ready = 1'b1;
         @(posedge clk);
         #1;
      end
      tx_ready = 1'b0;
      alu_delay = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'(1'b0));
      check({tag, "_A"}, 32'(alu_A), 32'(1'b0));
      check({tag, "_B"}, 32'(alu_B), 32'(1'b0));
      check({tag, "_fun"}, 32'(alu_fun), 32'(1'b0));
      check({tag, "_en"}, 32'(arith_enable), 32'(1'b0));
      check({tag, "_txv"}, 32'(tx_valid), 32'(1'b0));
      check({tag, "_txd"}, 32'(tx_data), 32'(1'b0));
      check({tag, "_err"}, 32'(err), 32'(1'b0));
   endtask

   initial begin
      RST = 1'b1;
      rx_data = '0;
      rx_valid = 1'b0;
      tx_ready = 1'b0;
      #1;
      check_reset_outputs("por");
      repeat (2) @(posedge clk);
      #1;
      RST = 1'b0;
      @(posedge clk);
      #1;

      run_frame(4'd0, 16'h0005, 16'h0003, 0, 0, 1'b0);
      run_frame(4'd1, 16'h0003, 16'h0005, 0, 0, 1'b0);
      run_frame(4'd3, 16'h0007, 16'h0000, 0, 0, 1'b0);
      run_frame(4'd2, 16'h0100, 16'h0100, 0, 10, 1'b0);
      run_frame(4'd3, 16'hFFF9, 16'h0002, 3, 0, 1'b1);

      bad_byte(8'h55);
      bad_byte(8'hA7);

      send_byte(8'hA0);
      send_byte(8'h05);
      RST = 1'b1;
      #1;
      check_reset_outputs("rst_mid_frame");
      @(posedge clk);
      #1;
      RST = 1'b0;
      @(posedge clk);
      #1;
      run_frame(4'd0, 16'h0001, 16'h0001, 0, 0, 1'b0);

      run_timeout(4'd2, 16'h1234, 16'h0042);
      run_frame(4'd1, 16'h8000, 16'h0001, 1, 2, 1'b0);

      alu_delay = 0;
      tx_ready = 1'b0;
      send_frame(4'd2, 16'h0003, 16'h0004);
      for (int c = 0; c < 10 && !tx_valid; c++) begin
         @(posedge clk);
         #1;
      end
      check("ms_valid_seen", 32'(tx_valid), 32'(1'b1));
      RST = 1'b1;
      #1;
      check_reset_outputs("rst_mid_send");
      @(posedge clk);
      #1;
      RST = 1'b0;
      tx_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         check("ms_quiet_valid", 32'(tx_valid), 32'(1'b0));
         check("ms_quiet_busy", 32'(busy), 32'(1'b0));
         @(posedge clk);
         #1;
      end
      tx_ready = 1'b0;

      for (int n = 0; n < 24; n++) begin
         logic [3:0]   f;
         logic [W-1:0] a;
         logic [W-1:0] b;
         f = 4'($urandom_range(0, 3));
         a = W'($urandom);
         b = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
         run_frame(f, a, b, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                   ($urandom_range(0, 2) == 0));
         if ($urandom_range(0, 3) == 0) bad_byte({4'hA, 4'($urandom_range(4, 15))});
         if ($urandom_range(0, 3) == 0) bad_byte({4'($urandom_range(0, 9)), 4'($urandom)});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter OPERAND_WIDTH, default 16, width of operands and ALU result; SHALL be a multiple of 8.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 rx_data  input  8  incoming command/operand byte.
REQ-005 rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-006 alu_A  output  OPERAND_WIDTH  signed operand A to arithmetic unit.
REQ-007 alu_B  output  OPERAND_WIDTH  signed operand B to arithmetic unit.
REQ-008 alu_fun  output  4  ALU function code (0 add, 1 sub, 2 mul, 3 div).
REQ-009 arith_enable  output  1  arithmetic unit enable.
REQ-010 arith_out  input  OPERAND_WIDTH  registered ALU result.
REQ-011 arith_flag  input  1  ALU result-valid flag.
REQ-012 tx_data  output  8  outgoing result byte.
REQ-013 tx_valid  output  1  tx_data valid; held until accepted.
REQ-014 tx_ready  input  1  downstream accepts byte when tx_valid and tx_ready both high.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 err  output  1  one-cycle pulse on protocol/timeout error.

Function
REQ-017 Frame: command byte {4'hA, fun}, then A low byte, A high byte, B low byte, B high byte (little-endian, OPERAND_WIDTH=16 case; wider widths add bytes LSB first).
REQ-018 States: IDLE, GET_AL, GET_AH, GET_BL, GET_BH, EXEC, WAIT, SEND_L, SEND_H; each GET_* advances only on rx_valid.
REQ-019 IDLE with rx_valid and upper nibble != 4'hA: byte dropped, err pulses, remain IDLE.
REQ-020 IDLE with tag 4'hA and fun > 3: err pulses, remain IDLE, no ALU activity.
REQ-021 Last operand byte accepted at edge N -> arith_enable high for exactly cycle N+1 (EXEC); alu_A/alu_B/alu_fun stable from EXEC until return to IDLE.
REQ-022 WAIT captures arith_out on first cycle arith_flag=1; nominal tx_valid assertion at cycle N+3.
REQ-023 WAIT with no arith_flag for 4 consecutive cycles: err pulses, return IDLE, no tx.
REQ-024 SEND_L drives result[7:0], SEND_H result[15:8]; each state advances only on tx_valid&&tx_ready; tx_data SHALL NOT change while tx_valid high and tx_ready low.
REQ-025 After SEND_H handshake: IDLE next cycle, tx_valid low; back-to-back frame command byte accepted that cycle.
REQ-026 rx_valid in EXEC/WAIT/SEND_*: byte dropped, err pulses, sequence continues unaffected.
REQ-027 Result treated as raw OPERAND_WIDTH bits; no saturation; divide-by-zero result (0) forwarded unchanged.

Reset
REQ-028 RST high: state IDLE, alu_A/alu_B/alu_fun/tx_data = 0, arith_enable/tx_valid/busy/err = 0, immediately and asynchronously.
REQ-029 RST mid-frame or mid-send: partial frame discarded, pending tx byte abandoned; no byte emitted after release until a new full frame.

Configuration
REQ-030 Macro ALU_SEQ_STATUS_EN: when defined, SEND_S state precedes SEND_L emitting status byte {4'hA, fun}; when undefined, only two result bytes sent and SEND_S absent.

Structure
REQ-031 Shared package alu_seq_pkg: state enum, FRAME_TAG (4'hA), FUN_ADD/SUB/MUL/DIV codes, WAIT_TIMEOUT (4).
REQ-032 Sub-module alu_seq_tx_ser: holds captured result, performs byte-wise valid/ready serialization; FSM instantiates it.

Verification
REQ-033 Frame A5? no: frame A0 05 00 03 00 -> arith_enable one cycle, fun=0, tx bytes 08 then 00.
REQ-034 Frame A1 03 00 05 00 -> tx FE FF; frame A3 07 00 00 00 -> tx 00 00.
REQ-035 Frame A2 00 01 00 01 with tx_ready low 10 cycles -> tx_valid held, tx_data=00 stable, completes after ready.
REQ-036 Byte 55 in IDLE -> err one cycle, no arith_enable; byte A7 -> err, no arith_enable.
REQ-037 RST pulse after A0 05 -> busy=0 immediately; subsequent A0 01 00 01 00 -> tx 02 00.
REQ-038 arith_flag forced low in WAIT -> err at 4th WAIT cycle, no tx_valid, busy drops.
